instruction_encoder: RTL

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Streaming MIPS instruction encoder: turns OpSel/field requests into 32-bit
// instruction words and writes them to consecutive instruction-memory addresses.
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 128
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        InValid,
  output logic        InReady,
  input  logic        InLast,
  input  logic [5:0]  OpSel,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [25:0] Target,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Full,
  output logic        Error,
  output logic [10:0] Count
);

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_NOP = 2'd3;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        enc_fmt;
  logic [5:0]        enc_op, enc_fn;
  logic [4:0]        enc_rs, enc_rt, enc_rd, enc_sh;
  logic              enc_bad;
  logic [31:0]       enc_word;
  logic              accept;
  logic              ready_d, wr_en_d, busy_d, done_d, full_d, error_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic [CNT_W-1:0]  count_d;

  // Opcode/funct lookup with table-fixed fields overriding the request fields
  always_comb begin
    enc_fmt = FMT_R;
    enc_op  = '0;
    enc_fn  = '0;
    enc_rs  = Rs;
    enc_rt  = Rt;
    enc_rd  = Rd;
    enc_sh  = '0;
    enc_bad = 1'b0;
    case (OpSel)
      6'd1:  begin enc_fn = 6'd0;  enc_rs = '0;   enc_sh = Shamt; end
      6'd2:  begin enc_op = 6'd28; enc_fn = 6'd0; enc_rd = '0; end
      6'd3:  begin enc_fn = 6'd2;  enc_rs = 5'd1; enc_sh = Shamt; end
      6'd4:  begin enc_fn = 6'd2;  enc_rs = '0;   enc_sh = Shamt; end
      6'd5:  begin enc_op = 6'd28; enc_fn = 6'd2; end
      6'd6:  begin enc_fn = 6'd3;  enc_rs = '0;   enc_sh = Shamt; end
      6'd7:  enc_fn = 6'd4;
      6'd8:  begin enc_op = 6'd28; enc_fn = 6'd4; enc_rd = '0; end
      6'd9:  begin enc_fn = 6'd6;  enc_sh = 5'd1; end
      6'd10: enc_fn = 6'd6;
      6'd11: enc_fn = 6'd7;
      6'd12: begin enc_fn = 6'd8;  enc_rt = '0; enc_rd = '0; end
      6'd13: enc_fn = 6'd10;
      6'd14: enc_fn = 6'd11;
      6'd15: begin enc_fn = 6'd16; enc_rs = '0; enc_rt = '0; end
      6'd16: begin enc_fn = 6'd17; enc_rt = '0; enc_rd = '0; end
      6'd17: begin enc_fn = 6'd18; enc_rs = '0; enc_rt = '0; end
      6'd18: begin enc_fn = 6'd19; enc_rt = '0; enc_rd = '0; end
      6'd19: begin enc_fn = 6'd24; enc_rd = '0; end
      6'd20: begin enc_fn = 6'd25; enc_rd = '0; end
      6'd21: enc_fn = 6'd32;
      6'd22: begin enc_op = 6'd31; enc_fn = 6'd32; enc_rs = '0; enc_sh = 5'd16; end
      6'd23: begin enc_op = 6'd31; enc_fn = 6'd32; enc_rs = '0; enc_sh = 5'd24; end
      6'd24: enc_fn = 6'd33;
      6'd25: enc_fn = 6'd34;
      6'd26: enc_fn = 6'd36;
      6'd27: enc_fn = 6'd37;
      6'd28: enc_fn = 6'd38;
      6'd29: enc_fn = 6'd39;
      6'd30: enc_fn = 6'd42;
      6'd31: enc_fn = 6'd43;
      6'd32: begin enc_fmt = FMT_I; enc_op = 6'd9;  end
      6'd33: begin enc_fmt = FMT_I; enc_op = 6'd10; end
      6'd34: begin enc_fmt = FMT_I; enc_op = 6'd11; end
      6'd35: begin enc_fmt = FMT_I; enc_op = 6'd12; end
      6'd36: begin enc_fmt = FMT_I; enc_op = 6'd13; end
      6'd37: begin enc_fmt = FMT_I; enc_op = 6'd14; end
      6'd38: begin enc_fmt = FMT_I; enc_op = 6'd15; enc_rs = '0; end
      6'd39: begin enc_fmt = FMT_J; enc_op = 6'd2; end
      6'd40: begin enc_fmt = FMT_J; enc_op = 6'd3; end
      6'd41: begin enc_fmt = FMT_I; enc_op = 6'd32; end
      6'd42: begin enc_fmt = FMT_I; enc_op = 6'd33; end
      6'd43: begin enc_fmt = FMT_I; enc_op = 6'd35; end
      6'd44: begin enc_fmt = FMT_I; enc_op = 6'd40; end
      6'd45: begin enc_fmt = FMT_I; enc_op = 6'd41; end
      6'd46: begin enc_fmt = FMT_I; enc_op = 6'd43; end
      6'd47: begin enc_fmt = FMT_I; enc_op = 6'd1; enc_rt = 5'd1; end
      6'd48: begin enc_fmt = FMT_I; enc_op = 6'd1; enc_rt = '0; end
      6'd49: begin enc_fmt = FMT_I; enc_op = 6'd4; end
      6'd50: begin enc_fmt = FMT_I; enc_op = 6'd5; end
      6'd51: begin enc_fmt = FMT_I; enc_op = 6'd6; enc_rt = '0; end
      6'd52: begin enc_fmt = FMT_I; enc_op = 6'd7; enc_rt = '0; end
      6'd53: begin enc_fmt = FMT_I; enc_op = 6'd8; end
      default: begin enc_fmt = FMT_NOP; enc_bad = (OpSel != 6'd0); end
    endcase
  end

  always_comb begin
    case (enc_fmt)
      FMT_R:   enc_word = {enc_op, enc_rs, enc_rt, enc_rd, enc_sh, enc_fn};
      FMT_I:   enc_word = {enc_op, enc_rs, enc_rt, Imm};
      FMT_J:   enc_word = {enc_op, Target};
      default: enc_word = 32'h0;
    endcase
  end

  assign accept = InValid & (state_q == RUN);

  // Next state and next registered outputs; Start wins over a same-cycle beat
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = WrAddr;
    wr_data_d = WrData;
    count_d   = Count;
    done_d    = Done;
    full_d    = Full;
    error_d   = Error;
    if (Start) begin
      state_d = RUN;
      count_d = '0;
      done_d  = 1'b0;
      full_d  = 1'b0;
      error_d = 1'b0;
    end else if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = BASE_ADDR + (ADDR_W'(Count) << 2);
      wr_data_d = enc_word;
      count_d   = Count + CNT_W'(1);
      error_d   = Error | enc_bad;
      if (InLast) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (Count == LAST_IDX) begin
        state_d = FULL;
        full_d  = 1'b1;
        error_d = 1'b1;
      end
    end
    ready_d = (state_d == RUN);
    busy_d  = ready_d | wr_en_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      InReady <= 1'b0;
      WrEn    <= 1'b0;
      WrAddr  <= '0;
      WrData  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Full    <= 1'b0;
      Error   <= 1'b0;
      Count   <= '0;
    end else begin
      state_q <= state_d;
      InReady <= ready_d;
      WrEn    <= wr_en_d;
      WrAddr  <= wr_addr_d;
      WrData  <= wr_data_d;
      Busy    <= busy_d;
      Done    <= done_d;
      Full    <= full_d;
      Error   <= error_d;
      Count   <= count_d;
    end
  end

endmodule
